// File: rtl/gpio_input_conditioner.sv
// Debounces N asynchronous board inputs: 2-flop synchronizer, optional inversion, shared
// sample-tick prescaler and per-bit stability counters, with registered edge pulses.
module gpio_input_conditioner #(
    parameter int unsigned N            = 21,
    parameter int unsigned TICK_CYCLES  = 50000,
    parameter int unsigned STABLE_TICKS = 10,
    parameter logic [N-1:0] INVERT      = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] raw_in,
    output logic [N-1:0] level,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic         any_edge
);

    localparam int unsigned PreW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned CntW = $clog2(STABLE_TICKS + 1);

    logic [N-1:0]    sync1_q, sync2_q;
    logic [N-1:0]    samp;
    logic [PreW-1:0] presc_q, presc_d;
    logic            tick;
    logic [CntW-1:0] cnt_q [N];
    logic [CntW-1:0] cnt_d [N];
    logic [N-1:0]    level_q, level_d;
    logic [N-1:0]    rise_q, rise_d;
    logic [N-1:0]    fall_q, fall_d;
    logic            any_edge_q, any_edge_d;

    assign samp    = sync2_q ^ INVERT;
    assign tick    = (presc_q == PreW'(TICK_CYCLES - 1));
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        cnt_d   = cnt_q;
        for (int i = 0; i < int'(N); i++) begin
            // Any agreeing sample throws away accumulated progress.
            if (samp[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == CntW'(STABLE_TICKS - 1)) begin
                    level_d[i] = samp[i];
                    cnt_d[i]   = '0;
                    rise_d[i]  = samp[i];
                    fall_d[i]  = ~samp[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        any_edge_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= INVERT;
            sync2_q    <= INVERT;
            presc_q    <= '0;
            level_q    <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            any_edge_q <= 1'b0;
            for (int i = 0; i < int'(N); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= raw_in;
            sync2_q    <= sync1_q;
            presc_q    <= presc_d;
            level_q    <= level_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            any_edge_q <= any_edge_d;
            for (int i = 0; i < int'(N); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign level    = level_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign any_edge = any_edge_q;

endmodule

// File: doc/gpio_input_conditioner.md
GPIO_INPUT_CONDITIONER -- requirements
Module: gpio_input_conditioner

Interface
REQ-001 SHALL provide parameter N, default 21, number of conditioned inputs (board KEY[3:1] plus SW[17:0]).
REQ-002 SHALL provide parameter TICK_CYCLES, default 50000, clk cycles per sample tick (1 ms at 50 MHz).
REQ-003 SHALL provide parameter STABLE_TICKS, default 10, consecutive disagreeing ticks required to accept a new level; legal range is at least 1.
REQ-004 SHALL provide parameter INVERT, default all zeros, N-bit mask; a set bit marks an active-low input.
REQ-005 SHALL provide port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-006 SHALL provide port reset, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL provide port raw_in, input, N bits, asynchronous board inputs.
REQ-008 SHALL provide port level, output, N bits, registered debounced active-high level that feeds the SoC GPIO input bus.
REQ-009 SHALL provide port rise, output, N bits, one-cycle pulse on an accepted 0->1 transition of level.
REQ-010 SHALL provide port fall, output, N bits, one-cycle pulse on an accepted 1->0 transition of level.
REQ-011 SHALL provide port any_edge, output, 1 bit, registered OR-reduction of rise and fall.

Function
REQ-012 SHALL pass each raw_in bit through a 2-flop synchronizer; sampled value s[i] = sync2[i] XOR INVERT[i].
REQ-013 SHALL keep one shared prescaler, width clog2(TICK_CYCLES), counting 0..TICK_CYCLES-1 and wrapping to 0.
REQ-014 SHALL assert internal tick for exactly one cycle when the prescaler equals TICK_CYCLES-1.
REQ-015 SHALL keep one counter per bit, cnt[i], width clog2(STABLE_TICKS+1).
REQ-016 SHALL clear cnt[i] in any cycle where s[i] equals level[i]; a single matching sample discards all accumulated progress (bounce rejection).
REQ-017 SHALL, when s[i] differs from level[i] and tick is high: if cnt[i] equals STABLE_TICKS-1, load level[i] with s[i] and clear cnt[i]; otherwise increment cnt[i].
REQ-018 SHALL hold cnt[i] unchanged when s[i] differs from level[i] and tick is low.
REQ-019 SHALL assert rise[i] (or fall[i]) in the same cycle level[i] takes its new value, for exactly one cycle; rise and fall are never both high for one bit.
REQ-020 SHALL assert any_edge in the same cycle as any rise or fall bit.
REQ-021 SHALL update all N bits independently; simultaneous acceptances on several bits produce coincident pulses.
REQ-022 SHALL have a latency from a raw_in change (held stable) to the level update of between (STABLE_TICKS-1)*TICK_CYCLES+3 and STABLE_TICKS*TICK_CYCLES+2 cycles inclusive.
REQ-023 SHALL never wrap or saturate cnt[i]; by construction it never exceeds STABLE_TICKS-1.

Reset
REQ-024 SHALL, while reset is high: set sync1 and sync2 to INVERT, prescaler to 0, all cnt to 0, and level, rise, fall and any_edge to 0.
REQ-025 SHALL generate no rise or fall pulse on the cycle reset asserts or releases, including when level was 1 before reset.
REQ-026 SHALL restart full debounce latency after a reset that arrives mid-count.

Verification
Use TICK_CYCLES=4, STABLE_TICKS=3 unless noted.
REQ-027 SHALL cover: reset, raw_in=0 held for 100 cycles -> level, rise, fall and any_edge all stay 0.
REQ-028 SHALL cover: raw_in[0] 0->1 and held -> level[0]=1 within 11..14 cycles, with rise[0] and any_edge high for exactly that one cycle; then 1->0 -> fall[0] one-cycle pulse at the same latency.
REQ-029 SHALL cover: raw_in[1] toggling every 3 cycles for 40 cycles, then held at 1 -> no pulse during toggling, then a single rise[1] within 11..14 cycles of the final edge.
REQ-030 SHALL cover: INVERT[0]=1 with raw_in[0]=1 through reset -> level[0]=0 and no pulse; raw_in[0]->0 -> level[0]=1 with one rise[0].
REQ-031 SHALL cover: raw_in[0] and raw_in[5] rising in the same cycle -> rise[0] and rise[5] in the same cycle, with any_edge high for exactly one cycle.
REQ-032 SHALL cover: a one-cycle reset pulse asserted when cnt[2]=2 -> level[2] stays 0, then rises 11..14 cycles after reset release while raw_in[2] is held at 1.
